// File: rtl/sram_pkg.sv
// sram_pkg: shared SRAM request-interface widths and responder state encoding
package sram_pkg;
    localparam int SRAM_ADDR_W = 18;
    localparam int SRAM_DATA_W = 32;
    localparam int SRAM_MASK_W = 4;
    localparam int SRAM_READ_LATENCY = 3;
    typedef enum logic [1:0] {CLEAR, RUN, STALL} resp_state_t;
endpackage

// File: rtl/sram_responder_if.sv
// sram_responder_if: SRAM request/response bus between arbiter (master) and responder (slave)
interface sram_responder_if;
    import sram_pkg::*;
    logic                   sram_addr_valid;
    logic                   sram_ready;
    logic [SRAM_ADDR_W-1:0] sram_addr;
    logic [SRAM_DATA_W-1:0] sram_data_in;
    logic [SRAM_MASK_W-1:0] sram_write_mask;
    logic [SRAM_DATA_W-1:0] sram_data_out;
    logic                   sram_data_out_valid;
    modport master (
        output sram_addr_valid, sram_addr, sram_data_in, sram_write_mask,
        input  sram_ready, sram_data_out, sram_data_out_valid
    );
    modport slave (
        input  sram_addr_valid, sram_addr, sram_data_in, sram_write_mask,
        output sram_ready, sram_data_out, sram_data_out_valid
    );
endinterface

// File: rtl/sram_byte_ram.sv
// sram_byte_ram: single-port 2^AW x 32 array with per-byte write enable and registered read
module sram_byte_ram
    import sram_pkg::*;
#(
    parameter int AW = 10
) (
    input  logic                   clk,
    input  logic [SRAM_MASK_W-1:0] we,
    input  logic [AW-1:0]          addr,
    input  logic [SRAM_DATA_W-1:0] wdata,
    output logic [SRAM_DATA_W-1:0] rdata
);
    logic [SRAM_DATA_W-1:0] mem [2**AW];
    always_ff @(posedge clk) begin
        for (int i = 0; i < SRAM_MASK_W; i++)
            if (we[i]) mem[addr][8*i +: 8] <= wdata[8*i +: 8];
        rdata <= mem[addr];
    end
endmodule

// File: rtl/sram_responder.sv
// sram_responder: SRAM responder, clears array after reset, 3-cycle read latency; SRAM_RESPONDER_STALL_EN injects periodic one-cycle stalls
module sram_responder
    import sram_pkg::*;
#(
    parameter int MEM_AW = 10,
    parameter int STALL_PERIOD = 16
) (
    input logic             sram_clock,
    input logic             reset,
    sram_responder_if.slave bus
);
    resp_state_t                  state, state_next;
    logic [MEM_AW-1:0]            clear_cnt;
    logic [SRAM_MASK_W-1:0]       ram_we;
    logic [MEM_AW-1:0]            ram_addr;
    logic [SRAM_DATA_W-1:0]       ram_wdata, ram_rdata, d1, d2;
    logic [SRAM_READ_LATENCY-1:0] rd_v;
    logic                         accept, rd_acc;
    logic                         unused_addr_bits;

    assign unused_addr_bits = ^bus.sram_addr[SRAM_ADDR_W-1:MEM_AW];
    assign accept = bus.sram_addr_valid & bus.sram_ready;
    assign rd_acc = accept & (bus.sram_write_mask == '0);

`ifdef SRAM_RESPONDER_STALL_EN
    localparam int SW = $clog2(STALL_PERIOD + 1);
    logic [SW-1:0] stall_cnt;
    always_ff @(posedge sram_clock) begin
        if (reset || state != RUN || state_next == STALL) stall_cnt <= '0;
        else stall_cnt <= stall_cnt + 1'b1;
    end
`else
    localparam int unused_stall_period = STALL_PERIOD;
`endif

    always_ff @(posedge sram_clock) begin
        state     <= reset ? CLEAR : state_next;
        clear_cnt <= (reset || state != CLEAR) ? '0 : clear_cnt + 1'b1;
    end

    always_comb begin
        state_next = state;
        if (state == CLEAR) state_next = &clear_cnt ? RUN : CLEAR;
`ifdef SRAM_RESPONDER_STALL_EN
        else if (state == RUN) state_next = (stall_cnt == SW'(STALL_PERIOD - 1)) ? STALL : RUN;
`endif
        else state_next = RUN;
    end

    // the clear sweep borrows the single RAM port; reset blocks any write on its edge
    always_comb begin
        bus.sram_ready = state == RUN;
        ram_we    = reset ? '0 : state == CLEAR ? '1 : accept ? bus.sram_write_mask : '0;
        ram_addr  = state == CLEAR ? clear_cnt : bus.sram_addr[MEM_AW-1:0];
        ram_wdata = state == CLEAR ? '0 : bus.sram_data_in;
    end

    sram_byte_ram #(.AW(MEM_AW)) u_ram (
        .clk   (sram_clock),
        .we    (ram_we),
        .addr  (ram_addr),
        .wdata (ram_wdata),
        .rdata (ram_rdata)
    );

    // rd_v[0] qualifies ram_rdata, rd_v[1] d1, rd_v[2] d2; output register adds the third edge
    always_ff @(posedge sram_clock) begin
        d1 <= ram_rdata;
        d2 <= d1;
        if (reset) begin
            rd_v                    <= '0;
            bus.sram_data_out_valid <= 1'b0;
            bus.sram_data_out       <= '0;
        end else begin
            rd_v                    <= {rd_v[SRAM_READ_LATENCY-2:0], rd_acc};
            bus.sram_data_out_valid <= rd_v[SRAM_READ_LATENCY-1];
            if (rd_v[SRAM_READ_LATENCY-1]) bus.sram_data_out <= d2;
        end
    end
endmodule

// File: doc/sram_responder.md
# sram_responder

Synchronous single-port SRAM responder on `sram_clock`: the memory-side end of the SRAM request interface driven by the SRAM arbiter. It accepts one read or masked-write request per cycle and returns read data with a fixed 3-cycle latency. It clears its array to zero after reset. It serves as the synthesizable on-chip SRAM substitute and as the bench memory for arbiter verification.

## Interface
- `MEM_AW`, 10: internal array address width; depth = 2^MEM_AW words.
- `STALL_PERIOD`, 16: cycles between injected stalls. Used only with `SRAM_RESPONDER_STALL_EN`.
- Clocking and reset (already decided): one clock, `sram_clock`; `reset` is synchronous and active-high.
- `sram_clock`  in  1  sole clock.
- `reset`  in  1  synchronous, active-high.
- `sram_addr_valid`  in  1  request present.
- `sram_ready`  out  1  responder can accept a request this cycle.
- `sram_addr`  in  18  word address; bits [17:MEM_AW] are ignored (aliasing).
- `sram_data_in`  in  32  write data.
- `sram_write_mask`  in  4  byte-enable; bit i enables byte [8i+7:8i]; 4'b0000 = read.
- `sram_data_out`  out  32  read data.
- `sram_data_out_valid`  out  1  one-cycle pulse qualifying `sram_data_out`.

## Operation
- States: CLEAR, RUN, and STALL (STALL exists only when `SRAM_RESPONDER_STALL_EN` is defined).
- Reset: state <= CLEAR; clear counter <= 0; `sram_ready`=0; `sram_data_out_valid`=0; `sram_data_out`=0; read pipeline valid bits flushed.
- CLEAR:
  - Writes 32'h0 to address clear_cnt each cycle; clear_cnt increments.
  - After address 2^MEM_AW-1 is written -> RUN. CLEAR lasts exactly 2^MEM_AW cycles.
- RUN:
  - `sram_ready`=1.
  - Accept = `sram_addr_valid` & `sram_ready`, sampled at the rising edge.
  - Write (mask != 0): masked bytes are updated at the accepting edge; unmasked bytes are kept. Writes produce no response.
  - Read (mask == 0): the array is read at the accepting edge and the data enters a 3-stage valid/data pipeline.
- Not-ready cycles: requests presented while `sram_ready`=0 are ignored. The initiator must hold the request until it is accepted.
- Ordering: a read returns the effect of every write accepted at an earlier edge. A write accepted after a read never alters that read's returned data.
- Pipeline behaviour in CLEAR/STALL: the pipeline keeps advancing, so in-flight reads still complete.
- `sram_data_out` holds its last value when `sram_data_out_valid`=0.
- Reset mid-operation: pending reads are discarded (no valid pulse after reset), the array is re-cleared, and pre-reset contents are lost.

## Timing
- Read accepted at edge k -> `sram_data_out_valid`=1 for exactly the cycle following edge k+3, with `sram_data_out` valid in that cycle.
- Back-to-back reads give back-to-back valid pulses at full throughput (1 per cycle).
- Interleaved read/write/read: each read's valid pulse stays exactly 3 edges after its own acceptance.
- `sram_ready` is registered (a function of state only). It never depends combinationally on the inputs.
- First possible acceptance: edge 2^MEM_AW+1 after reset deasserts.

## Configuration
- Macro: `SRAM_RESPONDER_STALL_EN`.
- Defined:
  - A free-running stall counter runs in RUN.
  - Every STALL_PERIOD RUN cycles the responder enters STALL for 1 cycle (`sram_ready`=0), then returns to RUN.
  - The counter resets to 0 on reset and on CLEAR exit.
  - Purpose: exercises initiator hold/backpressure.
- Undefined:
  - No STALL state and no counter.
  - `sram_ready` equals (state == RUN).
  - The `STALL_PERIOD` parameter is present but unused.

## Structure
- Shared package `sram_pkg`:
  - SRAM_ADDR_W=18, SRAM_DATA_W=32, SRAM_MASK_W=4, SRAM_READ_LATENCY=3.
  - Responder state encoding: CLEAR, RUN, STALL.
- Sub-module `sram_byte_ram`:
  - Single-port array, 2^MEM_AW x 32.
  - Per-byte write enable, registered read.
  - Written and read in the same always block.
- The top level owns the FSM, clear counter, stall counter, and the 3-stage valid/data pipeline.

## Test plan
- Reset, then read addr 0x00005 once in RUN -> `sram_ready` rises after 1024 cycles (MEM_AW=10); read returns 32'h00000000 with valid 3 edges after acceptance.
- Write 0xDEADBEEF to 0x00010 with mask 4'hF, then write 0x11223344 with mask 4'b0101, then read -> 32'hDE22BE44.
- Write 0xCAFEF00D to 0x00003; read 0x00003 at the next edge; write 0x0 with mask F at the next edge -> read returns 0xCAFEF00D.
- Aliasing: write 0xA5A5A5A5 to 0x00400 (MEM_AW=10), then read 0x00000 -> 0xA5A5A5A5.
- Ten back-to-back reads of addrs 0..9 pre-written with value = addr -> ten consecutive valid pulses with data 0..9 in order. Assert reset during the 5th pulse -> no valid after reset, and CLEAR restarts.
- With `SRAM_RESPONDER_STALL_EN`, STALL_PERIOD=4, initiator holding a request continuously -> `sram_ready` low every 5th cycle, the request held through the stall is accepted exactly once, and no read is lost or duplicated.
